// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one step per cycle over DATA_WIDTH
// cycles, with a stall request held until the result is ready.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle multiply).
module muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  startE,
   input  logic [2:0]            funct3E,
   input  logic [DATA_WIDTH-1:0] srcaE,
   input  logic [DATA_WIDTH-1:0] srcbE,
   input  logic                  flushE,
   output logic                  stallreqE,
   output logic                  busyE,
   output logic                  doneE,
   output logic [DATA_WIDTH-1:0] resultE
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [W-1:0]  MIN_NEG  = W'(1) << (W - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] DIV  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]     state;
   logic [CW-1:0]  cnt;
   logic [2:0]     op;
   logic           signA;
   logic           signB;
   logic [2*W-1:0] acc;     // multiply: {partial product, multiplier}; divide: {remainder, quotient}
   logic [W-1:0]   opB;     // multiplicand or divisor magnitude

   // Decode of the requested operation and operand magnitudes
   logic           signedA;
   logic           signedB;
   logic           aNeg;
   logic           bNeg;
   logic [W-1:0]   aMag;
   logic [W-1:0]   bMag;
   logic           divZero;
   logic           divOvf;
   logic [W-1:0]   specialRes;

   // Operand decode for the request presented in IDLE
   always_comb begin
      signedA    = funct3E[2] ? ~funct3E[0] : (funct3E[1:0] != 2'b11);
      signedB    = funct3E[2] ? ~funct3E[0] : ~funct3E[1];
      aNeg       = signedA & srcaE[W-1];
      bNeg       = signedB & srcbE[W-1];
      aMag       = aNeg ? (-srcaE) : srcaE;
      bMag       = bNeg ? (-srcbE) : srcbE;
      divZero    = (srcbE == '0);
      divOvf     = ~funct3E[0] & (srcaE == MIN_NEG) & (srcbE == '1);
      specialRes = '0;
      if (divZero)
         specialRes = funct3E[1] ? srcaE : '1;
      else
         specialRes = funct3E[1] ? '0 : srcaE;
   end

   // Restoring divide step and signed fix-up of the final quotient/remainder
   logic [W:0]     divShift;
   logic           divGe;
   logic [W-1:0]   remNext;
   logic [W-1:0]   quoNext;
   logic [W-1:0]   divRes;

   // One restoring-divide iteration on the registered state
   always_comb begin
      divShift = {acc[2*W-1:W], acc[W-1]};
      divGe    = (divShift >= {1'b0, opB});
      remNext  = divGe ? (divShift[W-1:0] - opB) : divShift[W-1:0];
      quoNext  = {acc[W-2:0], divGe};
      divRes   = '0;
      if (op[1])
         divRes = signA ? (-remNext) : remNext;
      else
         divRes = (signA ^ signB) ? (-quoNext) : quoNext;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*W-1:0] extA;
   logic [2*W-1:0] extB;
   logic [2*W-1:0] fastProd;
   logic [W-1:0]   fastRes;

   // Sign-extended operands make the truncated 2W product correct for every mix
   always_comb begin
      extA     = {{W{aNeg}}, srcaE};
      extB     = {{W{bNeg}}, srcbE};
      fastProd = extA * extB;
      fastRes  = (funct3E == 3'b000) ? fastProd[W-1:0] : fastProd[2*W-1:W];
   end
`else
   logic [W:0]     mulSum;
   logic [2*W-1:0] mulNext;
   logic [2*W-1:0] mulProd;
   logic [W-1:0]   mulRes;

   // One shift-add multiply iteration and sign fix-up of the final product
   always_comb begin
      mulSum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opB} : '0);
      mulNext = {mulSum, acc[W-1:1]};
      mulProd = (signA ^ signB) ? (-mulNext) : mulNext;
      mulRes  = (op == 3'b000) ? mulProd[W-1:0] : mulProd[2*W-1:W];
   end
`endif

   // Stall the pipeline from the accepted start until the iteration finishes
   always_comb begin
      stallreqE = ((state == IDLE) & startE & ~flushE) | (state == MUL) | (state == DIV);
   end

   // Control FSM, iteration datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         op      <= '0;
         signA   <= 1'b0;
         signB   <= 1'b0;
         acc     <= '0;
         opB     <= '0;
         busyE   <= 1'b0;
         doneE   <= 1'b0;
         resultE <= '0;
      end else begin
         case (state)
            IDLE: begin
               doneE <= 1'b0;
               busyE <= 1'b0;
               if (startE & ~flushE) begin
                  op    <= funct3E;
                  signA <= aNeg;
                  signB <= bNeg;
                  if (funct3E[2]) begin
                     opB <= bMag;
                     acc <= {{W{1'b0}}, aMag};
                  end else begin
                     opB <= aMag;
                     acc <= {{W{1'b0}}, bMag};
                  end
                  if (!funct3E[2]) begin
`ifdef MULDIV_FAST_MUL_EN
                     state   <= DONE;
                     doneE   <= 1'b1;
                     resultE <= fastRes;
`else
                     state   <= MUL;
                     busyE   <= 1'b1;
                     cnt     <= CNT_INIT;
`endif
                  end else if (divZero | divOvf) begin
                     state   <= DONE;
                     doneE   <= 1'b1;
                     resultE <= specialRes;
                  end else begin
                     state   <= DIV;
                     busyE   <= 1'b1;
                     cnt     <= CNT_INIT;
                  end
               end
            end
`ifndef MULDIV_FAST_MUL_EN
            MUL: begin
               if (flushE) begin
                  state <= IDLE;
                  busyE <= 1'b0;
                  cnt   <= '0;
               end else begin
                  acc <= mulNext;
                  cnt <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) begin
                     state   <= DONE;
                     busyE   <= 1'b0;
                     doneE   <= 1'b1;
                     resultE <= mulRes;
                  end
               end
            end
`endif
            DIV: begin
               if (flushE) begin
                  state <= IDLE;
                  busyE <= 1'b0;
                  cnt   <= '0;
               end else begin
                  acc <= {remNext, quoNext};
                  cnt <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) begin
                     state   <= DONE;
                     busyE   <= 1'b0;
                     doneE   <= 1'b1;
                     resultE <= divRes;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               doneE <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busyE <= 1'b0;
               doneE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit at 32 and 16 bits,
// directed cases plus random operations against an arithmetic reference model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start32 = 1'b0;
   logic [2:0]  f32 = '0;
   logic [31:0] a32 = '0;
   logic [31:0] b32 = '0;
   logic        flush32 = 1'b0;
   logic        stall32, busy32, done32;
   logic [31:0] res32;

   logic        start16 = 1'b0;
   logic [2:0]  f16 = '0;
   logic [15:0] a16 = '0;
   logic [15:0] b16 = '0;
   logic        flush16 = 1'b0;
   logic        stall16, busy16, done16;
   logic [15:0] res16;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] lastRes32 = '0;

   always #5 clk = ~clk;

   muldiv_unit #(.DATA_WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .startE(start32), .funct3E(f32), .srcaE(a32), .srcbE(b32),
      .flushE(flush32), .stallreqE(stall32), .busyE(busy32), .doneE(done32), .resultE(res32)
   );

   muldiv_unit #(.DATA_WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .startE(start16), .funct3E(f16), .srcaE(a16), .srcbE(b16),
      .flushE(flush16), .stallreqE(stall16), .busyE(busy16), .doneE(done16), .resultE(res16)
   );

   task automatic checkEq(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands' numeric values
   function automatic logic [63:0] refModel(int w, logic [2:0] f, logic [63:0] a, logic [63:0] b);
      logic [63:0]         mask;
      logic signed [127:0] x, y, r;
      bit                  sA, sB;
      mask = (64'd1 << w) - 64'd1;
      sA = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6);
      sB = (f == 3'd0) || (f == 3'd1) || (f == 3'd4) || (f == 3'd6);
      a = a & mask;
      b = b & mask;
      x = {64'd0, a};
      y = {64'd0, b};
      if (sA && a[w-1]) x = x - (128'sd1 <<< w);
      if (sB && b[w-1]) y = y - (128'sd1 <<< w);
      if (!f[2]) begin
         r = x * y;
         if (f != 3'd0) r = r >>> w;
      end else if (b == 64'd0) begin
         r = f[1] ? x : -128'sd1;
      end else if (sA && (x == -(128'sd1 <<< (w - 1))) && (y == -128'sd1)) begin
         r = f[1] ? 128'sd0 : x;
      end else begin
         r = f[1] ? (x % y) : (x / y);
      end
      return r[63:0] & mask;
   endfunction

   function automatic logic curDone(int w);
      return (w == 16) ? done16 : done32;
   endfunction

   function automatic logic curStall(int w);
      return (w == 16) ? stall16 : stall32;
   endfunction

   function automatic logic curBusy(int w);
      return (w == 16) ? busy16 : busy32;
   endfunction

   function automatic logic [63:0] curRes(int w);
      return (w == 16) ? 64'(res16) : 64'(res32);
   endfunction

   task automatic setIn(int w, logic s, logic [2:0] f, logic [63:0] a, logic [63:0] b);
      if (w == 16) begin
         start16 = s; f16 = f; a16 = a[15:0]; b16 = b[15:0];
      end else begin
         start32 = s; f32 = f; a32 = a[31:0]; b32 = b[31:0];
      end
   endtask

   task automatic setStart(int w, logic s);
      if (w == 16) start16 = s;
      else start32 = s;
   endtask

   function automatic logic [63:0] pickOperand(int w);
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return mask;
         2: return 64'd1 << (w - 1);
         3: return 64'd1;
         default: return 64'($urandom) & mask;
      endcase
   endfunction

   // Issue one operation, then check latency, stall/busy windows and result
   task automatic doOp(int w, logic [2:0] f, logic [63:0] a, logic [63:0] b,
                       logic [63:0] expRes, bit hold);
      logic [63:0] mask, minV;
      bit          special, fastMul, seen;
      int          expLat, cycles, stallCnt, busyCnt;
      mask = (64'd1 << w) - 64'd1;
      minV = 64'd1 << (w - 1);
      a = a & mask;
      b = b & mask;
      special = f[2] && ((b == 64'd0) || (!f[0] && (a == minV) && (b == mask)));
      fastMul = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
      fastMul = !f[2];
`endif
      expLat = (special || fastMul) ? 1 : w + 1;
      @(negedge clk);
      setIn(w, 1'b1, f, a, b);
      #1;
      checkEq("done_low_at_start", 64'(curDone(w)), 64'd0);
      checkEq("stall_at_start", 64'(curStall(w)), 64'd1);
      stallCnt = 1;
      busyCnt = 0;
      cycles = 0;
      seen = 1'b0;
      while (!seen && cycles < w + 10) begin
         @(negedge clk);
         cycles++;
         if (hold) setIn(w, 1'b1, f, 64'($urandom), 64'($urandom));
         else setStart(w, 1'b0);
         #1;
         if (curDone(w)) seen = 1'b1;
         else begin
            stallCnt += int'(curStall(w));
            busyCnt += int'(curBusy(w));
         end
      end
      setStart(w, 1'b0);
      checkEq("done_seen", 64'(seen), 64'd1);
      checkEq("latency", 64'(cycles), 64'(expLat));
      checkEq("stall_cycles", 64'(stallCnt), 64'(expLat));
      checkEq("busy_cycles", 64'(busyCnt), 64'(expLat - 1));
      checkEq("stall_in_done", 64'(curStall(w)), 64'd0);
      checkEq("result", curRes(w), expRes & mask);
      if (w == 32) lastRes32 = expRes & mask;
   endtask

   logic [2:0]  dF [12];
   logic [31:0] dA [12];
   logic [31:0] dB [12];
   logic [31:0] dE [12];
   bit          sawDone;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      dF = '{3'd0, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6, 3'd1};
      dA = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
             32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'h80000000};
      dB = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
             32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
      dE = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
             32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'h40000000};

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      checkEq("reset_done", 64'(done32), 64'd0);
      checkEq("reset_busy", 64'(busy32), 64'd0);
      checkEq("reset_stall", 64'(stall32), 64'd0);
      checkEq("reset_result", 64'(res32), 64'd0);
      rst = 1'b0;

      // Directed cases, issued back-to-back
      for (int i = 0; i < 12; i++)
         doOp(32, dF[i], 64'(dA[i]), 64'(dB[i]), 64'(dE[i]), 1'b0);

      // startE held through the whole operation with changing operands
      doOp(32, 3'd0, 64'd7, 64'hFFFFFFFD, 64'hFFFFFFEB, 1'b1);
      @(negedge clk);
      #1;
      checkEq("hold_no_restart_busy", 64'(busy32), 64'd0);
      checkEq("hold_no_restart_done", 64'(done32), 64'd0);
      checkEq("hold_no_restart_stall", 64'(stall32), 64'd0);

      // Flush at iteration 10 of a divide
      @(negedge clk);
      setIn(32, 1'b1, 3'd5, 64'd1000, 64'd3);
      @(negedge clk);
      setStart(32, 1'b0);
      repeat (9) @(negedge clk);
      flush32 = 1'b1;
      @(negedge clk);
      flush32 = 1'b0;
      #1;
      checkEq("flush_busy", 64'(busy32), 64'd0);
      checkEq("flush_stall", 64'(stall32), 64'd0);
      checkEq("flush_done", 64'(done32), 64'd0);
      checkEq("flush_result_kept", 64'(res32), lastRes32);
      sawDone = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done32) sawDone = 1'b1;
      end
      checkEq("flush_no_done", 64'(sawDone), 64'd0);

      // Reset in the middle of a divide
      setIn(32, 1'b1, 3'd4, 64'hFFFFFFF9, 64'd2);
      @(negedge clk);
      setStart(32, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkEq("rst_mid_busy", 64'(busy32), 64'd0);
      checkEq("rst_mid_done", 64'(done32), 64'd0);
      checkEq("rst_mid_stall", 64'(stall32), 64'd0);
      checkEq("rst_mid_result", 64'(res32), 64'd0);
      lastRes32 = '0;
      sawDone = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done32) sawDone = 1'b1;
      end
      checkEq("rst_no_done", 64'(sawDone), 64'd0);
      doOp(32, 3'd6, 64'd100, 64'd7, 64'd2, 1'b0);

      // startE and flushE together in IDLE: a divide-by-zero would finish next cycle
      @(negedge clk);
      setIn(32, 1'b1, 3'd5, 64'd5, 64'd0);
      flush32 = 1'b1;
      #1;
      checkEq("startflush_stall", 64'(stall32), 64'd0);
      @(negedge clk);
      setStart(32, 1'b0);
      flush32 = 1'b0;
      #1;
      checkEq("startflush_done", 64'(done32), 64'd0);
      checkEq("startflush_busy", 64'(busy32), 64'd0);
      checkEq("startflush_result", 64'(res32), lastRes32);

      // Random operations at both widths
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  f;
         logic [63:0] a, b;
         f = 3'($urandom_range(0, 7));
         a = pickOperand(32);
         b = pickOperand(32);
         doOp(32, f, a, b, refModel(32, f, a, b), 1'b0);
      end
      for (int i = 0; i < 60; i++) begin
         logic [2:0]  f;
         logic [63:0] a, b;
         f = 3'($urandom_range(0, 7));
         a = pickOperand(16);
         b = pickOperand(16);
         doOp(16, f, a, b, refModel(16, f, a, b), 1'b0);
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the execute stage of the pipelined core. It accepts one operation from execute, runs a multi-cycle shift-add multiply or restoring divide, and holds the pipeline through a stall request until it returns the result. It sits beside the ALU; its result feeds the execute-to-memory register through the ALU result path. It is parametrised in operand width and optionally provides a single-cycle multiply.

## Interface

Parameters:
- DATA_WIDTH, 32: operand and result width. Must be even and ≥ 8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- startE  in  1  request a new operation; sampled only in IDLE.
- funct3E  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- srcaE  in  DATA_WIDTH  rs1 operand (dividend / multiplicand).
- srcbE  in  DATA_WIDTH  rs2 operand (divisor / multiplier).
- flushE  in  1  abort the current or requested operation.
- stallreqE  out  1  combinational: `(state==IDLE & startE & ~flushE) | state==MUL | state==DIV`.
- busyE  out  1  registered: high in MUL and DIV.
- doneE  out  1  registered: one-cycle pulse in DONE.
- resultE  out  DATA_WIDTH  result; valid when doneE is high and held until the next accepted start.

## Operation

States are IDLE, MUL, DIV and DONE.

- **Reset:** state=IDLE. busyE=0, doneE=0, resultE=0, and the iteration counter is cleared.
- **IDLE:** if `startE & ~flushE`, the unit latches funct3E and the operand magnitudes. It records the operand signs:
  - srca is signed for MUL, MULH, MULHSU, DIV and REM.
  - srcb is signed for MUL, MULH, DIV and REM.
  - For MUL, the signedness does not affect the low word.
- **Next state from IDLE:**
  - MUL if funct3E[2]=0.
  - DONE for the special divide cases below.
  - DIV otherwise.
- **MUL:** one shift-add step per cycle over DATA_WIDTH cycles into a 2×DATA_WIDTH accumulator.
  - After the last step, the 2W product is negated if the operand signs differ (only for the signed sides).
  - MUL takes the low word. MULH, MULHSU and MULHU take the high word.
  - Next state is DONE.
- **DIV:** one restoring step per cycle over DATA_WIDTH cycles on the magnitudes.
  - The quotient is negated if the signs differ (signed ops only).
  - The remainder takes the sign of the dividend.
  - DIV and DIVU output the quotient; REM and REMU output the remainder.
  - Next state is DONE.
- **Special divide cases (no iteration):**
  - Divisor 0: the quotient is all ones (DIV/DIVU) and the remainder is srcaE (REM/REMU).
  - Signed overflow (srca = −2^(W−1), srcb = −1): DIV returns srcaE and REM returns 0.
- **DONE:** doneE=1 and resultE is updated. Next state is IDLE.
- **Flush:** flushE in MUL, DIV or DONE forces IDLE on the next edge.
  - doneE is deasserted and resultE keeps its previous value.
  - flushE in IDLE blocks acceptance of a start.
- **Ignored starts:** startE in any state other than IDLE is ignored.
- **Back-to-back:** a start in the cycle after DONE (state is IDLE again) is accepted.
- **Counter:** ⌈log2(DATA_WIDTH+1)⌉ bits. Loaded on entry to MUL/DIV and terminates at 0; there is no wrap-around.

## Timing

- Start is sampled at edge k.
  - Iterative MUL/DIV: state is MUL/DIV for cycles k+1 … k+DATA_WIDTH, and doneE is high in cycle k+DATA_WIDTH+1. Latency is DATA_WIDTH+1 (33 cycles at 32 bits).
  - Special divide cases: doneE is high in cycle k+1.
- stallreqE is high from the start cycle (cycle k) through cycle k+DATA_WIDTH. It is low in the DONE cycle, so the pipeline register captures resultE at the end of that cycle.
- Reset mid-operation: the unit returns to IDLE on the next edge with all outputs at their reset values. A result is never produced.
- Simultaneous `startE & flushE` in IDLE: not accepted, and stallreqE=0.

## Configuration

- MULDIV_FAST_MUL_EN: when defined, the multiply ops compute the full 2W signed/unsigned product in one cycle using a single multiply operator.
  - MUL-class ops go IDLE → DONE, with doneE in cycle k+1 and stallreqE high only in cycle k.
  - The MUL state is not synthesised.
  - Divide behaviour is unchanged.
- When undefined, the iterative path described above is used.

## Test plan

- **Iterative multiply, 32-bit:**
  - MUL 7×−3 → resultE=0xFFFFFFEB, doneE exactly 33 cycles after start, stallreqE high for 33 cycles.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- **Divide:**
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
  - Each with 33-cycle latency.
- **Special cases, each with doneE one cycle after start:**
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- **Flush and reset:**
  - flushE at iteration 10 → IDLE next cycle, no doneE, resultE unchanged.
  - rst mid-DIV → all outputs 0 on the next cycle.
  - A following start completes normally.
- **Hazards:**
  - startE held high while busy → no second operation.
  - Start the cycle after DONE → accepted.
  - startE & flushE together in IDLE → not accepted.
- **MULDIV_FAST_MUL_EN:**
  - MULH 0x80000000×0x80000000 → 0x40000000 with doneE at k+1.
  - Repeat with the macro off → same value at k+33.
  - Run with DATA_WIDTH=16 and check against a reference model.
